// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: op encodings, flag bit positions and data width
// used by the shared-adder block and its clients.
package arith_pkg;

  localparam int DATA_W = 32;
  localparam int FLAG_W = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Operands as presented to the adder: SUB is already folded into ~b / cin=1.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
  } adder_in_t;

  function automatic logic [FLAG_W-1:0] pack_flags(
    input logic [DATA_W-1:0] result,
    input logic              carry,
    input logic              ovf
  );
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_N] = result[DATA_W-1];
    f[FLAG_Z] = (result == '0);
    f[FLAG_C] = carry;
    f[FLAG_V] = ovf;
    return f;
  endfunction

endpackage

// File: rtl/adder_32bit.sv
// Plain 32-bit adder with carry-in, carry-out and signed-overflow detection.
module adder_32bit
  import arith_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              overflow
);

  logic [DATA_W:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
  assign sum      = full_sum[DATA_W-1:0];
  assign cout     = full_sum[DATA_W];
  // Signed overflow: both operands share a sign that the result does not.
  assign overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (with wrap);
// ptr moves past the winner only when the caller signals a completed handshake.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W-1:0] cand;
  logic            found;
  int              idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = ID_W'(idx);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      if (grant_idx == ID_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + ID_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one adder_32bit among NUM_REQ requesters through a round-robin arbiter
// and a two-stage pipeline (operand register, result register) with backpressure.
module adder_arbiter
  import arith_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_op,
  input  logic [NUM_REQ-1:0]        req_cin,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic [FLAG_W-1:0]         rsp_flags
);

  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
    assign b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
  end

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;
  logic               s1_can_load;
  logic               s2_can_load;

  // Stage 1: operand register
  logic              s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]   s1_id_q,    s1_id_d;
  adder_in_t         s1_ops_q,   s1_ops_d;

  // Stage 2: result register, drives the response channel directly
  logic              s2_valid_q,  s2_valid_d;
  logic [ID_W-1:0]   s2_id_q,     s2_id_d;
  logic [DATA_W-1:0] s2_result_q, s2_result_d;
  logic [FLAG_W-1:0] s2_flags_q,  s2_flags_d;

  logic [DATA_W-1:0] add_sum;
  logic              add_cout;
  logic              add_ovf;

  assign s2_can_load = !s2_valid_q || rsp_ready;
  assign s1_can_load = !s1_valid_q || s2_can_load;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = rst ? '0 : (grant & {NUM_REQ{s1_can_load}});
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_ops_d   = s1_ops_q;
    if (s1_can_load) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_id_d    = grant_idx;
        s1_ops_d.a = a_arr[grant_idx];
        // Subtraction as a + ~b + 1, so C=1 means no borrow.
        if (req_op[grant_idx] == OP_SUB) begin
          s1_ops_d.b   = ~b_arr[grant_idx];
          s1_ops_d.cin = 1'b1;
        end else begin
          s1_ops_d.b   = b_arr[grant_idx];
          s1_ops_d.cin = req_cin[grant_idx];
        end
      end
    end
  end

  adder_32bit u_adder (
    .a        (s1_ops_q.a),
    .b        (s1_ops_q.b),
    .cin      (s1_ops_q.cin),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow (add_ovf)
  );

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_id_d     = s2_id_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;
    if (s2_can_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_id_d     = s1_id_q;
        s2_result_d = add_sum;
        s2_flags_d  = pack_flags(add_sum, add_cout, add_ovf);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_ops_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_id_q     <= '0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_ops_q    <= s1_ops_d;
      s2_valid_q  <= s2_valid_d;
      s2_id_q     <= s2_id_d;
      s2_result_q <= s2_result_d;
      s2_flags_q  <= s2_flags_d;
    end
  end

  assign rsp_valid  = s2_valid_q;
  assign rsp_id     = s2_id_q;
  assign rsp_result = s2_result_q;
  assign rsp_flags  = s2_flags_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: scoreboard fed on each accepted request,
// drained on each response handshake, plus directed checks for corner cases.
module tb_adder_arbiter;
  import arith_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_op, req_cin;
  logic [N*32-1:0] req_a, req_b;
  logic            rsp_valid, rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [31:0]     rsp_result;
  logic [3:0]      rsp_flags;

  always #5 clk = ~clk;

  adder_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_cin    (req_cin),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    result;
    logic [3:0]     flags;
  } rsp_t;

  rsp_t exp_q[$];
  int   grant_log[$];
  int   rsp_count     = 0;
  int   checks_total  = 0;
  int   checks_passed = 0;
  rsp_t mon_e;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference arithmetic written independently of the a + ~b + 1 trick.
  function automatic rsp_t model(input int id, input logic op, input logic cin,
                                 input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    rsp_t        e;
    if (op == 1'b0) begin
      s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      r = s[31:0];
      c = s[32];
      v = (a[31] == b[31]) && (r[31] != a[31]);
    end else begin
      r = a - b;
      c = (a >= b);
      v = (a[31] != b[31]) && (r[31] != a[31]);
    end
    e.id     = IDW'(id);
    e.result = r;
    e.flags  = {r[31], (r == 32'd0), c, v};
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back(model(i, req_op[i], req_cin[i], req_a[i*32 +: 32], req_b[i*32 +: 32]));
          grant_log.push_back(i);
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_count++;
        $display("rsp id=%0d result=%08h flags=%04b", rsp_id, rsp_result, rsp_flags);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("sb_id", 64'(rsp_id), 64'(mon_e.id));
          check_eq("sb_result", 64'(rsp_result), 64'(mon_e.result));
          check_eq("sb_flags", 64'(rsp_flags), 64'(mon_e.flags));
        end
      end
    end
  end

  task automatic set_req(input int id, input logic op, input logic cin,
                         input logic [31:0] a, input logic [31:0] b);
    req_op[id]          = op;
    req_cin[id]         = cin;
    req_a[id*32 +: 32]  = a;
    req_b[id*32 +: 32]  = b;
  endtask

  task automatic send(input int id, input logic op, input logic cin,
                      input logic [31:0] a, input logic [31:0] b);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    set_req(id, op, cin, a, b);
    req_valid[id] = 1'b1;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!got) check_eq("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic do_one(input string tag, input int id, input logic op, input logic cin,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [3:0] exp_flags);
    send(id, op, cin, a, b);
    @(negedge clk);
    check_eq({tag, "_lat1"}, 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check_eq({tag, "_lat2"}, 64'(rsp_valid), 64'd1);
    check_eq({tag, "_id"}, 64'(rsp_id), 64'(id));
    check_eq({tag, "_result"}, 64'(rsp_result), 64'(exp_res));
    check_eq({tag, "_flags"}, 64'(rsp_flags), 64'(exp_flags));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          acc, base, c0, c1;
    bit          stable;
    logic [37:0] snap;

    rst = 1'b1; req_valid = '0; req_op = '0; req_cin = '0;
    req_a = '0; req_b = '0; rsp_ready = 1'b1;
    c0 = 0; c1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("por_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("por_rsp_result", 64'(rsp_result), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill the pipe, then reset with ops in flight
    rsp_ready = 1'b0;
    set_req(0, OP_ADD, 1'b0, 32'd1, 32'd2);
    set_req(1, OP_SUB, 1'b0, 32'd9, 32'd3);
    req_valid = 4'b0011;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_id", 64'(rsp_id), 64'd0);
    check_eq("rst_rsp_result", 64'(rsp_result), 64'd0);
    check_eq("rst_rsp_flags", 64'(rsp_flags), 64'd0);
    check_eq("rst_req_ready2", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, OP_ADD, 1'b0, 32'd10, 32'd20);
    set_req(2, OP_ADD, 1'b0, 32'd30, 32'd40);
    req_valid = 4'b0101;
    @(negedge clk);
    check_eq("rr_first_grant", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    @(negedge clk);
    check_eq("rr_second_grant", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);

    // Directed arithmetic cases
    do_one("add_ovf", 1, OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001);
    do_one("sub_eq",  3, OP_SUB, 1'b0, 32'd5, 32'd5, 32'd0, 4'b0110);
    do_one("sub_brw", 3, OP_SUB, 1'b0, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'b1000);
    do_one("adc",     0, OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'b0110);
    repeat (3) @(posedge clk);

    // Backpressure: only two ops fit while the consumer stalls
    #1;
    rsp_ready = 1'b0;
    set_req(0, OP_ADD, 1'b0, 32'h1111_1111, 32'h2222_2222);
    set_req(1, OP_SUB, 1'b0, 32'h0000_0010, 32'h0000_0020);
    set_req(2, OP_ADD, 1'b1, 32'h8000_0000, 32'h8000_0000);
    req_valid = 4'b0111;
    acc = 0;
    repeat (6) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) acc++;
    end
    check_eq("bp_accepts", 64'(acc), 64'd2);
    check_eq("bp_ready_low", 64'(req_ready), 64'd0);
    check_eq("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    snap = {rsp_id, rsp_result, rsp_flags};
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if ({rsp_id, rsp_result, rsp_flags} !== snap || !rsp_valid) stable = 1'b0;
    end
    check_eq("bp_stable", 64'(stable), 64'd1);
    @(posedge clk); #1;
    base = rsp_count;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("bp_drained", 64'(rsp_count - base), 64'd2);
    check_eq("bp_sb_empty", 64'(exp_q.size()), 64'd0);
    check_eq("bp_idle", 64'(rsp_valid), 64'd0);

    // Fairness and throughput with all requesters busy
    @(posedge clk); #1;
    grant_log.delete();
    for (int i = 0; i < N; i++) set_req(i, 1'($urandom), 1'($urandom), $urandom, $urandom);
    req_valid = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == 4)  c0 = rsp_count;
      if (c == 16) c1 = rsp_count;
      for (int i = 0; i < N; i++) set_req(i, 1'($urandom), 1'($urandom), $urandom, $urandom);
    end
    req_valid = '0;
    repeat (5) @(posedge clk);
    check_eq("fair_throughput", 64'(c1 - c0), 64'd12);
    check_eq("fair_grants", 64'(grant_log.size() >= 16), 64'd1);
    for (int i = 1; i < grant_log.size(); i++)
      check_eq("fair_order", 64'(grant_log[i]), 64'((grant_log[i-1] + 1) % N));

    @(negedge clk);
    check_eq("final_sb_empty", 64'(exp_q.size()), 64'd0);
    check_eq("final_idle", 64'(rsp_valid), 64'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
